// File: rtl/clause_store_mr.sv
// Multi-read-port append-only clause store feeding the BCP engines.
// Optional in-place overwrite port enabled by defining CDB_OVERWRITE_EN.
module clause_store_mr #(
   parameter int unsigned NUM_CLAUSES     = 64,
   parameter int unsigned VARS_PER_CLAUSE = 5,
   parameter int unsigned VAR_BITS        = 8,
   parameter int unsigned NUM_RD          = 2,
   localparam int unsigned CB = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
   localparam int unsigned VW = VARS_PER_CLAUSE * VAR_BITS
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         push,
   input  logic [VARS_PER_CLAUSE-1:0]   mask_in,
   input  logic [VARS_PER_CLAUSE-1:0]   pole_in,
   input  logic [VW-1:0]                var_in,
   output logic                         push_ok,
   output logic                         push_err,
   output logic [CB-1:0]                push_idx,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD*CB-1:0]         rd_idx,
   output logic [NUM_RD-1:0]            rd_valid,
   output logic [NUM_RD-1:0]            rd_error,
   output logic [NUM_RD*VARS_PER_CLAUSE-1:0] rd_mask,
   output logic [NUM_RD*VARS_PER_CLAUSE-1:0] rd_pole,
   output logic [NUM_RD*VW-1:0]         rd_var,
   output logic [CB:0]                  count,
   output logic                         full,
`ifdef CDB_OVERWRITE_EN
   input  logic                         wr_en,
   input  logic [CB-1:0]                wr_idx,
   output logic                         wr_err,
`endif
   output logic                         empty
);

   localparam logic [CB:0] MaxCount = (CB+1)'(NUM_CLAUSES);

   logic [VARS_PER_CLAUSE-1:0] mem_mask [NUM_CLAUSES];
   logic [VARS_PER_CLAUSE-1:0] mem_pole [NUM_CLAUSES];
   logic [VW-1:0]              mem_var  [NUM_CLAUSES];

   logic [CB:0]   count_q, count_d;
   logic          push_ok_q, push_err_q;
   logic          push_err_d;
   logic [CB-1:0] push_idx_q;
   logic          push_acc;
   logic          wr_take;
   logic          wr_do;

   logic [VARS_PER_CLAUSE-1:0] norm_pole;
   logic [VW-1:0]              norm_var;

   logic [NUM_RD-1:0]                 rd_valid_q, rd_valid_d;
   logic [NUM_RD-1:0]                 rd_error_q, rd_error_d;
   logic [NUM_RD*VARS_PER_CLAUSE-1:0] rd_mask_q, rd_mask_d;
   logic [NUM_RD*VARS_PER_CLAUSE-1:0] rd_pole_q, rd_pole_d;
   logic [NUM_RD*VW-1:0]              rd_var_q, rd_var_d;

   assign full  = (count_q == MaxCount);
   assign empty = (count_q == '0);
   assign count = count_q;

   // Absent literal slots are stored as zero so consumers can compare whole clauses.
   always_comb begin
      norm_pole = pole_in & mask_in;
      norm_var  = '0;
      for (int j = 0; j < int'(VARS_PER_CLAUSE); j++) begin
         if (mask_in[j]) norm_var[j*VAR_BITS +: VAR_BITS] = var_in[j*VAR_BITS +: VAR_BITS];
      end
   end

`ifdef CDB_OVERWRITE_EN
   logic wr_err_q;
   assign wr_take = wr_en;
   assign wr_do   = wr_en && ({1'b0, wr_idx} < count_q) && !clear;
   assign wr_err  = wr_err_q;

   always_ff @(posedge clock) begin
      if (reset) wr_err_q <= 1'b0;
      else       wr_err_q <= wr_en && ({1'b0, wr_idx} >= count_q);
   end
`else
   assign wr_take = 1'b0;
   assign wr_do   = 1'b0;
`endif

   // An overwrite request always steals the write port from a push.
   assign push_acc   = push && !full && !clear && !wr_take;
   assign push_err_d = push && !clear && (full || wr_take);

   always_comb begin
      count_d = count_q;
      if (clear)         count_d = '0;
      else if (push_acc) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q    <= '0;
         push_ok_q  <= 1'b0;
         push_err_q <= 1'b0;
         push_idx_q <= '0;
      end else begin
         count_q    <= count_d;
         push_ok_q  <= push_acc;
         push_err_q <= push_err_d;
         push_idx_q <= push_acc ? count_q[CB-1:0] : '0;
      end
   end

   // Storage is intentionally not reset; entries at or above count are unreachable.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (push_acc) begin
            mem_mask[count_q[CB-1:0]] <= mask_in;
            mem_pole[count_q[CB-1:0]] <= norm_pole;
            mem_var[count_q[CB-1:0]]  <= norm_var;
         end
`ifdef CDB_OVERWRITE_EN
         if (wr_do) begin
            mem_mask[wr_idx] <= mask_in;
            mem_pole[wr_idx] <= norm_pole;
            mem_var[wr_idx]  <= norm_var;
         end
`endif
      end
   end

   // Reads see pre-edge count and storage, giving read-before-write ordering.
   always_comb begin
      rd_valid_d = '0;
      rd_error_d = '0;
      rd_mask_d  = '0;
      rd_pole_d  = '0;
      rd_var_d   = '0;
      for (int p = 0; p < int'(NUM_RD); p++) begin
         if (rd_en[p]) begin
            if ({1'b0, rd_idx[p*CB +: CB]} < count_q) begin
               rd_valid_d[p] = 1'b1;
               rd_mask_d[p*VARS_PER_CLAUSE +: VARS_PER_CLAUSE] = mem_mask[rd_idx[p*CB +: CB]];
               rd_pole_d[p*VARS_PER_CLAUSE +: VARS_PER_CLAUSE] = mem_pole[rd_idx[p*CB +: CB]];
               rd_var_d[p*VW +: VW] = mem_var[rd_idx[p*CB +: CB]];
            end else begin
               rd_error_d[p] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid_q <= '0;
         rd_error_q <= '0;
         rd_mask_q  <= '0;
         rd_pole_q  <= '0;
         rd_var_q   <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_error_q <= rd_error_d;
         rd_mask_q  <= rd_mask_d;
         rd_pole_q  <= rd_pole_d;
         rd_var_q   <= rd_var_d;
      end
   end

   assign push_ok  = push_ok_q;
   assign push_err = push_err_q;
   assign push_idx = push_idx_q;
   assign rd_valid = rd_valid_q;
   assign rd_error = rd_error_q;
   assign rd_mask  = rd_mask_q;
   assign rd_pole  = rd_pole_q;
   assign rd_var   = rd_var_q;

endmodule
